// File: rtl/synaptic_charge_accumulator_if.sv
// Handshake and bus bundle between the synapse controller/consumer and the charge accumulator.
// The controller and consumer side drives through master; the accumulator uses slave.
interface synaptic_charge_accumulator_if #(
    parameter int N     = 256,
    parameter int MEM_W = 8
) ();
    localparam int CW = $clog2(N / 8);
    localparam int IW = $clog2(N);

    logic                    charge_enable_i;
    logic [CW-1:0]           count_i;
    logic [31:0]             synapse_data_i;
    logic signed [MEM_W-1:0] threshold_i;
    logic                    clear_i;
    logic                    ready_o;
    logic                    spike_valid_o;
    logic                    spike_ready_i;
    logic [IW-1:0]           spike_idx_o;
    logic                    overflow_o;

    modport slave (
        input  charge_enable_i, count_i, synapse_data_i, threshold_i, clear_i, spike_ready_i,
        output ready_o, spike_valid_o, spike_idx_o, overflow_o
    );

    modport master (
        output charge_enable_i, count_i, synapse_data_i, threshold_i, clear_i, spike_ready_i,
        input  ready_o, spike_valid_o, spike_idx_o, overflow_o
    );
endinterface

// File: rtl/synaptic_charge_accumulator.sv
// Integrates 8 signed 4-bit synaptic weights per cycle into saturating membrane potentials,
// fires neurons at threshold and drains fired indices one per cycle from a spike-event FIFO.
module synaptic_charge_accumulator #(
    parameter int N              = 256,
    parameter int MEM_W          = 8,
    parameter int SPK_FIFO_DEPTH = 4
) (
    input logic                          CLK,
    input logic                          RST,
    synaptic_charge_accumulator_if.slave bus
);
    localparam int CW = $clog2(N / 8);
    localparam int IW = $clog2(N);
    localparam int PW = $clog2(SPK_FIFO_DEPTH);
    localparam int OW = PW + 1;
    localparam logic [OW-1:0] DEPTH_C     = OW'(SPK_FIFO_DEPTH);
    localparam logic [OW-1:0] READY_MAX_C = OW'(SPK_FIFO_DEPTH - 2);

    function automatic logic [2:0] lowest_set(input logic [7:0] m);
        lowest_set = 3'd0;
        for (int b = 7; b >= 0; b--) begin
            if (m[b]) lowest_set = 3'(b);
        end
    endfunction

    function automatic logic [MEM_W-1:0] sat_add(input logic [MEM_W-1:0] p, input logic [3:0] w);
        logic [MEM_W:0] s;
        s = {p[MEM_W-1], p} + {{(MEM_W-3){w[3]}}, w};
        if (s[MEM_W] != s[MEM_W-1]) begin
            sat_add = s[MEM_W] ? {1'b1, {(MEM_W-1){1'b0}}} : {1'b0, {(MEM_W-1){1'b1}}};
        end else begin
            sat_add = s[MEM_W-1:0];
        end
    endfunction

    logic signed [MEM_W-1:0] pot_q [N];
    logic signed [MEM_W-1:0] pot_d [N];
    logic                    valid_q, valid_d;
    logic [CW-1:0]           count_q, count_d;
    logic [CW-1:0]           fifo_cnt_q  [SPK_FIFO_DEPTH];
    logic [CW-1:0]           fifo_cnt_d  [SPK_FIFO_DEPTH];
    logic [7:0]              fifo_mask_q [SPK_FIFO_DEPTH];
    logic [7:0]              fifo_mask_d [SPK_FIFO_DEPTH];
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [OW-1:0]           occ_q, occ_d;
    logic                    overflow_q, overflow_d;

    logic signed [MEM_W-1:0] lane_sum_s [8];
    logic [IW-1:0]           lane_idx_s [8];
    logic [7:0]              fire_mask_s, head_mask_s;
    logic                    spike_valid_s, spike_take_s, head_last_s, pop_s, push_req_s, push_s;

    always_comb begin
        fire_mask_s = 8'd0;
        for (int k = 0; k < 8; k++) begin
            lane_idx_s[k] = {count_q, 3'(k)};
            lane_sum_s[k] = sat_add(pot_q[lane_idx_s[k]], bus.synapse_data_i[4*k +: 4]);
            if (lane_sum_s[k] >= bus.threshold_i) begin
                fire_mask_s[k] = 1'b1;
            end else begin
                fire_mask_s[k] = 1'b0;
            end
        end
    end

    always_comb begin
        pot_d = pot_q;
        if (bus.clear_i) begin
            for (int i = 0; i < N; i++) pot_d[i] = {MEM_W{1'b0}};
        end else if (valid_q) begin
            for (int k = 0; k < 8; k++) begin
                pot_d[lane_idx_s[k]] = fire_mask_s[k] ? {MEM_W{1'b0}} : lane_sum_s[k];
            end
        end else begin
            pot_d = pot_q;
        end
    end

    // A push into a full FIFO still lands when the head pops in the same cycle.
    always_comb begin
        spike_valid_s = (occ_q != {OW{1'b0}});
        head_mask_s   = fifo_mask_q[rd_ptr_q];
        spike_take_s  = spike_valid_s & bus.spike_ready_i;
        head_last_s   = ((head_mask_s & (head_mask_s - 8'd1)) == 8'd0);
        pop_s         = spike_take_s & head_last_s;
        push_req_s    = valid_q & (fire_mask_s != 8'd0);
        push_s        = push_req_s & ((occ_q != DEPTH_C) | pop_s);
    end

    always_comb begin
        valid_d     = bus.charge_enable_i;
        count_d     = bus.count_i;
        fifo_cnt_d  = fifo_cnt_q;
        fifo_mask_d = fifo_mask_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        occ_d       = occ_q;
        overflow_d  = overflow_q;
        if (bus.clear_i) begin
            valid_d    = 1'b0;
            count_d    = {CW{1'b0}};
            rd_ptr_d   = {PW{1'b0}};
            wr_ptr_d   = {PW{1'b0}};
            occ_d      = {OW{1'b0}};
            overflow_d = 1'b0;
            for (int e = 0; e < SPK_FIFO_DEPTH; e++) begin
                fifo_cnt_d[e]  = {CW{1'b0}};
                fifo_mask_d[e] = 8'd0;
            end
        end else begin
            if (spike_take_s && !head_last_s) begin
                fifo_mask_d[rd_ptr_q] = head_mask_s & (head_mask_s - 8'd1);
            end else begin
                fifo_mask_d[rd_ptr_q] = fifo_mask_q[rd_ptr_q];
            end
            if (push_s) begin
                fifo_cnt_d[wr_ptr_q]  = count_q;
                fifo_mask_d[wr_ptr_q] = fire_mask_s;
                wr_ptr_d              = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   occ_d = occ_q + {{(OW-1){1'b0}}, 1'b1};
                2'b01:   occ_d = occ_q - {{(OW-1){1'b0}}, 1'b1};
                default: occ_d = occ_q;
            endcase
            overflow_d = overflow_q | (push_req_s & ~push_s);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < N; i++) pot_q[i] <= {MEM_W{1'b0}};
            for (int e = 0; e < SPK_FIFO_DEPTH; e++) begin
                fifo_cnt_q[e]  <= {CW{1'b0}};
                fifo_mask_q[e] <= 8'd0;
            end
            valid_q    <= 1'b0;
            count_q    <= {CW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            wr_ptr_q   <= {PW{1'b0}};
            occ_q      <= {OW{1'b0}};
            overflow_q <= 1'b0;
        end else begin
            pot_q       <= pot_d;
            fifo_cnt_q  <= fifo_cnt_d;
            fifo_mask_q <= fifo_mask_d;
            valid_q     <= valid_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            occ_q       <= occ_d;
            overflow_q  <= overflow_d;
        end
    end

    // One slot stays reserved for a word that is already in flight.
    assign bus.ready_o       = (occ_q + OW'(valid_q)) <= READY_MAX_C;
    assign bus.spike_valid_o = spike_valid_s;
    assign bus.spike_idx_o   = spike_valid_s ? {fifo_cnt_q[rd_ptr_q], lowest_set(head_mask_s)} : {IW{1'b0}};
    assign bus.overflow_o    = overflow_q;
endmodule

// File: tb/tb_synaptic_charge_accumulator.sv
// Directed bench for synaptic_charge_accumulator: saturation, firing, FIFO drain/overflow and clear.
module tb_synaptic_charge_accumulator;
    logic clk;
    logic rst;
    int   tests;
    int   failed;
    int   fires;

    synaptic_charge_accumulator_if #(.N(256), .MEM_W(8)) bus ();

    synaptic_charge_accumulator #(.N(256), .MEM_W(8), .SPK_FIFO_DEPTH(4)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pot(input int i);
        return dut.pot_q[i];
    endfunction

    // Issue one read at t, present its data during t+1, return at t+2.
    task automatic charge(input logic [4:0] cnt, input logic [31:0] data);
        bus.charge_enable_i = 1'b1;
        bus.count_i         = cnt;
        tick();
        bus.charge_enable_i = 1'b0;
        bus.synapse_data_i  = data;
        tick();
        bus.synapse_data_i  = 32'd0;
    endtask

    task automatic pulse_clear();
        bus.clear_i = 1'b1;
        tick();
        bus.clear_i = 1'b0;
    endtask

    initial begin
        tests               = 0;
        failed              = 0;
        fires               = 0;
        rst                 = 1'b1;
        bus.charge_enable_i = 1'b0;
        bus.count_i         = 5'd0;
        bus.synapse_data_i  = 32'd0;
        bus.threshold_i     = 8'sd10;
        bus.clear_i         = 1'b0;
        bus.spike_ready_i   = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        check("rst_valid", 32'(bus.spike_valid_o), 32'd0);
        check("rst_idx", 32'(bus.spike_idx_o), 32'd0);
        check("rst_ready", 32'(bus.ready_o), 32'd1);
        check("rst_ovf", 32'(bus.overflow_o), 32'd0);
        check("rst_pot24", 32'(pot(24)), 32'd0);

        // accumulate below threshold, then reach it exactly
        charge(5'd3, 32'h0000_0005);
        check("t1_pot24_a", 32'(pot(24)), 32'd5);
        check("t1_novalid", 32'(bus.spike_valid_o), 32'd0);
        charge(5'd3, 32'h0000_0005);
        check("t1_valid", 32'(bus.spike_valid_o), 32'd1);
        check("t1_idx", 32'(bus.spike_idx_o), 32'd24);
        check("t1_pot24_b", 32'(pot(24)), 32'd0);
        tick();
        check("t1_popped", 32'(bus.spike_valid_o), 32'd0);

        // negative weights in every lane
        charge(5'd0, 32'hFFFF_FFFF);
        check("t2_pot0", 32'(pot(0)), 32'hFF);
        check("t2_pot7", 32'(pot(7)), 32'hFF);
        check("t2_novalid", 32'(bus.spike_valid_o), 32'd0);
        pulse_clear();

        // negative saturation, then positive saturation firing exactly once
        bus.threshold_i = 8'sd100;
        for (int i = 0; i < 20; i++) begin
            charge(5'd1, 32'h0000_0008);
            check("t3_neg_novalid", 32'(bus.spike_valid_o), 32'd0);
        end
        check("t3_pot8_min", 32'(pot(8)), 32'h80);
        bus.threshold_i = 8'sd127;
        for (int i = 0; i < 40; i++) begin
            charge(5'd1, 32'h0000_0007);
            if (bus.spike_valid_o) begin
                fires++;
                check("t3_fire_idx", 32'(bus.spike_idx_o), 32'd8);
            end
        end
        check("t3_fire_count", 32'(fires), 32'd1);
        check("t3_pot8_end", 32'(pot(8)), 32'h15);
        pulse_clear();

        // full 8-spike word drains in ascending order, one per cycle
        bus.threshold_i = 8'sd1;
        charge(5'd31, 32'h1111_1111);
        for (int i = 0; i < 8; i++) begin
            check("t4_valid", 32'(bus.spike_valid_o), 32'd1);
            check("t4_idx", 32'(bus.spike_idx_o), 32'(248 + i));
            tick();
        end
        check("t4_drained", 32'(bus.spike_valid_o), 32'd0);

        // back-pressure, ready_o throttling and overflow
        bus.spike_ready_i = 1'b0;
        charge(5'd0, 32'h0000_0001);
        check("t5_valid", 32'(bus.spike_valid_o), 32'd1);
        charge(5'd1, 32'h0000_0001);
        charge(5'd2, 32'h0000_0001);
        check("t5_ready", 32'(bus.ready_o), 32'd0);
        check("t5_ovf_a", 32'(bus.overflow_o), 32'd0);
        check("t5_idx_hold", 32'(bus.spike_idx_o), 32'd0);
        charge(5'd3, 32'h0000_0001);
        check("t5_ovf_b", 32'(bus.overflow_o), 32'd0);
        charge(5'd4, 32'h0000_0001);
        check("t5_ovf_c", 32'(bus.overflow_o), 32'd1);
        check("t5_pot32", 32'(pot(32)), 32'd0);
        bus.spike_ready_i = 1'b1;
        check("t5_d0", 32'(bus.spike_idx_o), 32'd0);
        tick();
        check("t5_d1", 32'(bus.spike_idx_o), 32'd8);
        tick();
        check("t5_d2", 32'(bus.spike_idx_o), 32'd16);
        tick();
        check("t5_d3_valid", 32'(bus.spike_valid_o), 32'd1);
        check("t5_d3", 32'(bus.spike_idx_o), 32'd24);
        tick();
        check("t5_empty", 32'(bus.spike_valid_o), 32'd0);
        check("t5_ovf_sticky", 32'(bus.overflow_o), 32'd1);

        // clear in the middle of a drain
        charge(5'd0, 32'hFFFF_FFFF);
        check("t6_pot0_pre", 32'(pot(0)), 32'hFF);
        charge(5'd31, 32'h1111_1111);
        check("t6_i0", 32'(bus.spike_idx_o), 32'd248);
        tick();
        check("t6_i1", 32'(bus.spike_idx_o), 32'd249);
        pulse_clear();
        check("t6_valid", 32'(bus.spike_valid_o), 32'd0);
        check("t6_ready", 32'(bus.ready_o), 32'd1);
        check("t6_ovf", 32'(bus.overflow_o), 32'd0);
        check("t6_idx", 32'(bus.spike_idx_o), 32'd0);
        check("t6_pot0", 32'(pot(0)), 32'd0);
        check("t6_pot7", 32'(pot(7)), 32'd0);
        check("t6_pot248", 32'(pot(248)), 32'd0);
        check("t6_pot255", 32'(pot(255)), 32'd0);
        tick();
        check("t6_stays_empty", 32'(bus.spike_valid_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
